// File: rtl/digital_safe_seq.sv
// digital_safe_seq: multi-digit code lock with retry counting, timed lockout
// with alarm, and timed auto-relock, driving a 7-segment status display.
module digital_safe_seq #(
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned CODE_LEN       = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] PASSWORD = 16'hA3C5,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000,
    parameter int unsigned OPEN_CYCLES    = 500
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [DIGIT_W-1:0]                 digit_in,
    input  logic                               digit_valid,
    input  logic                               lock_req,
    output logic [6:0]                         display,
    output logic                               unlocked,
    output logic                               alarm,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left
);

    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned TMAX   = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W  = $clog2(TMAX + 1);

    localparam logic [6:0] SEG_L = 7'b1000111;
    localparam logic [6:0] SEG_E = 7'b0111111;
    localparam logic [6:0] SEG_U = 7'b1000001;
    localparam logic [6:0] SEG_X = 7'b0000110;

    typedef enum logic [1:0] {
        S_LOCKED  = 2'd0,
        S_ENTRY   = 2'd1,
        S_OPEN    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mis_q, mis_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [6:0]         display_q;
    logic               unlocked_q;
    logic               alarm_q;

    logic [DIGIT_W-1:0] pw_digit;
    logic               mis_all;
    logic               last_digit;
    logic               take_digit;

    function automatic logic [6:0] seg_of(state_e s);
        unique case (s)
            S_LOCKED:  seg_of = SEG_L;
            S_ENTRY:   seg_of = SEG_E;
            S_OPEN:    seg_of = SEG_U;
            default:   seg_of = SEG_X;
        endcase
    endfunction

    // Select the password digit expected at the current index (first digit is MSB).
    always_comb begin
        pw_digit = '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (idx_q == IDX_W'(i)) begin
                pw_digit = PASSWORD[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    // Next-state logic: digit accumulation, code evaluation, and timers.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mis_d      = mis_q;
        timer_d    = timer_q;
        tries_d    = tries_q;
        take_digit = 1'b0;
        mis_all    = mis_q | (digit_in != pw_digit);
        last_digit = (idx_q == IDX_W'(CODE_LEN - 1));

        unique case (state_q)
            S_LOCKED: begin
                take_digit = digit_valid;
            end
            S_ENTRY: begin
                if (lock_req) begin
                    state_d = S_LOCKED;
                    idx_d   = '0;
                    mis_d   = 1'b0;
                end else begin
                    take_digit = digit_valid;
                end
            end
            S_OPEN: begin
                if (lock_req || timer_q == '0) begin
                    state_d = S_LOCKED;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                if (timer_q == '0) begin
                    state_d = S_LOCKED;
                    tries_d = TRY_W'(MAX_TRIES);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
        endcase

        // Accepted digit: either keep collecting or judge the complete code.
        if (take_digit) begin
            if (!last_digit) begin
                state_d = S_ENTRY;
                idx_d   = idx_q + IDX_W'(1);
                mis_d   = mis_all;
            end else begin
                idx_d = '0;
                mis_d = 1'b0;
                if (!mis_all) begin
                    state_d = S_OPEN;
                    tries_d = TRY_W'(MAX_TRIES);
                    timer_d = TMR_W'(OPEN_CYCLES - 1);
                end else if (tries_q > TRY_W'(1)) begin
                    state_d = S_LOCKED;
                    tries_d = tries_q - TRY_W'(1);
                end else begin
                    state_d = S_LOCKOUT;
                    tries_d = '0;
                    timer_d = TMR_W'(LOCKOUT_CYCLES - 1);
                end
            end
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_LOCKED;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            timer_q <= '0;
            tries_q <= TRY_W'(MAX_TRIES);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            timer_q <= timer_d;
            tries_q <= tries_d;
        end
    end

    // Registered Moore decodes of the next state so outputs change on the same edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            display_q  <= SEG_L;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            display_q  <= seg_of(state_d);
            unlocked_q <= (state_d == S_OPEN);
            alarm_q    <= (state_d == S_LOCKOUT);
        end
    end

    assign display    = display_q;
    assign unlocked   = unlocked_q;
    assign alarm      = alarm_q;
    assign tries_left = tries_q;

endmodule

// File: doc/digital_safe_seq.md
# digital_safe_seq

Parametrised multi-digit successor to the single-cycle 4-bit safe lock. Accepts a code as a sequence of validated digits, compares it against a parameter password, and drives a 7-segment status display. Adds retry counting, timed lockout with alarm, and timed auto-relock. Sits between the keypad digit decoder and the display/actuator logic of the safe.

## Interface
- DIGIT_W, 4: bits per entered digit
- CODE_LEN, 4: digits per code (≥1)
- PASSWORD, 16'hA3C5: CODE_LEN*DIGIT_W bits; first digit entered is compared to the most significant DIGIT_W bits
- MAX_TRIES, 3: consecutive wrong codes allowed before lockout (≥1)
- LOCKOUT_CYCLES, 1000: clock cycles spent in LOCKOUT (≥1)
- OPEN_CYCLES, 500: clock cycles OPEN lasts without lock_req (≥1)

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- digit_in  in  DIGIT_W  digit value, sampled when digit_valid=1
- digit_valid  in  1  one-cycle strobe; every high cycle is one digit
- lock_req  in  1  relock (OPEN) / abort entry (ENTRY)
- display  out  7  active-low segments {g,f,e,d,c,b,a}
- unlocked  out  1  high only in OPEN
- alarm  out  1  high only in LOCKOUT
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts

## Operation
- States: LOCKED, ENTRY, OPEN, LOCKOUT. Outputs are Moore decodes of registered state/counters.
- display: LOCKED 7'b1000111 ('L'), ENTRY 7'b0111111 ('-'), OPEN 7'b1000001 ('U'), LOCKOUT 7'b0000110 ('E').
- Reset (reset_n=0 at an edge): state LOCKED, digit index 0, mismatch flag 0, timer 0, tries_left=MAX_TRIES; display 'L', unlocked 0, alarm 0. Reset overrides every other input, in any state.
- LOCKED: digit_valid → compare digit against digit 0 of PASSWORD, set mismatch flag on difference. If CODE_LEN=1, evaluate immediately (see below); else → ENTRY, index=1. lock_req ignored.
- ENTRY: each digit_valid compares digit_in to PASSWORD digit [index], ORs into mismatch flag, index++. On the CODE_LEN-th digit, evaluate:
  - match (flag clear incl. this digit): → OPEN, tries_left=MAX_TRIES, timer loaded.
  - mismatch, tries_left>1: tries_left--, → LOCKED.
  - mismatch, tries_left=1: tries_left=0, → LOCKOUT, timer loaded.
  - index and flag cleared on every exit from ENTRY.
- ENTRY + lock_req: abort → LOCKED, index/flag cleared, tries_left unchanged; lock_req wins over a simultaneous digit_valid (digit dropped).
- OPEN: stays OPEN_CYCLES cycles, then → LOCKED. lock_req → LOCKED at that edge. digit_valid ignored.
- LOCKOUT: stays LOCKOUT_CYCLES cycles, then → LOCKED with tries_left=MAX_TRIES. digit_valid and lock_req ignored.
- Wrong codes are counted only across full-length entries; aborts do not count. Correct code restores tries_left.

## Timing
- Digit sampled at edge N; state/outputs reflect it immediately after edge N (no extra latency).
- Final correct digit at edge N: unlocked=1, display 'U' from edge N through edge N+OPEN_CYCLES-1; LOCKED after edge N+OPEN_CYCLES.
- Lockout entered at edge N: alarm=1 for exactly LOCKOUT_CYCLES cycles; LOCKED, tries_left=MAX_TRIES after edge N+LOCKOUT_CYCLES.
- Timer width $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1); no wrap — counts down to expiry only.
- OPEN timer expiry and lock_req in the same cycle: single → LOCKED, no other effect.
- Back-to-back digit_valid (every cycle) fully supported; gaps of any length allowed; no entry timeout.

## Test plan
- Reset, then digits A,3,C,5 on consecutive cycles → unlocked=1, display 7'b1000001 after 4th edge; unlocked drops after exactly 500 cycles; tries_left=3.
- Correct code, then lock_req 10 cycles later → LOCKED, display 7'b1000111, unlocked=0 on that edge.
- Codes A,3,C,4 then 0,0,0,0 → tries_left 2 then 1, display 'L'; third wrong code → alarm=1, display 7'b0000110 for 1000 cycles, digits during lockout ignored; then tries_left=3.
- A,3 then lock_req with simultaneous digit_valid → LOCKED, tries_left unchanged; fresh A,3,C,5 opens.
- Two wrong codes then A,3,C,5 → OPEN, tries_left=3; one later wrong code → tries_left=2, no lockout.
- reset_n=0 mid-ENTRY (after A,3), mid-OPEN, mid-LOCKOUT → next cycle LOCKED, 'L', alarm=0, tries_left=3; rerun with CODE_LEN=1, PASSWORD=4'hA: single A opens.
